// File: rtl/storage_access_responder.sv
// Storage-side responder: range-checks one CPU storage request at a time, translates it
// into the storage-local space and drives a slow storage port with configurable wait states.
module storage_access_responder #(
    parameter int DATA_WIDTH            = 32,
    parameter int INPUT_WIDTH           = 32,
    parameter int MEMORY_ADDRESS_WIDTH  = 13,
    parameter int STORAGE_ADDRESS_WIDTH = 15,
    parameter int WAIT_STATES           = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             request,
    input  logic                             write_enable,
    input  logic [INPUT_WIDTH-1:0]           address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic [STORAGE_ADDRESS_WIDTH-1:0] st_address,
    output logic [DATA_WIDTH-1:0]            st_write_data,
    output logic                             st_write_enable,
    output logic                             st_read_enable,
    input  logic [DATA_WIDTH-1:0]            st_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, FAULT, DONE} state_t;

    // One extra bit so the exclusive upper bound cannot wrap for wide storage windows.
    localparam logic [INPUT_WIDTH:0] WIDE_ONE      = {{INPUT_WIDTH{1'b0}}, 1'b1};
    localparam logic [INPUT_WIDTH:0] STORAGE_START = WIDE_ONE << MEMORY_ADDRESS_WIDTH;
    localparam logic [INPUT_WIDTH:0] STORAGE_LIMIT = STORAGE_START + (WIDE_ONE << STORAGE_ADDRESS_WIDTH);
    localparam logic [STORAGE_ADDRESS_WIDTH-1:0] START_LOW = STORAGE_START[STORAGE_ADDRESS_WIDTH-1:0];

    localparam int COUNT_WIDTH = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_INIT = COUNT_WIDTH'(WAIT_STATES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    state_t                             state;
    logic [COUNT_WIDTH-1:0]             count;
    logic                               is_write;
    logic                               in_range;
    logic [STORAGE_ADDRESS_WIDTH-1:0]   local_address;

    // Truncated subtraction equals subtracting the truncated operands, so only the low bits are needed.
    assign in_range      = ({1'b0, address} >= STORAGE_START) && ({1'b0, address} < STORAGE_LIMIT);
    assign local_address = address[STORAGE_ADDRESS_WIDTH-1:0] - START_LOW;

    // NOTE: every register below is written with <= so all updates use pre-edge values,
    // and every output (including read_data) is cleared by the asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            is_write        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            read_data       <= '0;
            st_address      <= '0;
            st_write_data   <= '0;
            st_write_enable <= 1'b0;
            st_read_enable  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        is_write      <= write_enable;
                        st_write_data <= write_data;
                        busy          <= 1'b1;
                        if (in_range) begin
                            st_address      <= local_address;
                            count           <= COUNT_INIT;
                            st_read_enable  <= ~write_enable;
                            st_write_enable <= write_enable;
                            state           <= ACCESS;
                        end else begin
                            state <= FAULT;
                        end
                    end
                end
                ACCESS: begin
                    // The write strobe is a single-cycle pulse; the read enable spans the access.
                    st_write_enable <= 1'b0;
                    if (count == '0) begin
                        st_read_enable <= 1'b0;
                        done           <= 1'b1;
                        error          <= 1'b0;
                        if (!is_write)
                            read_data <= st_read_data;
                        state <= DONE;
                    end else begin
                        count <= count - COUNT_ONE;
                    end
                end
                FAULT: begin
                    done  <= 1'b1;
                    error <= 1'b1;
                    if (!is_write)
                        read_data <= '0;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_access_responder.sv
// Self-checking bench for storage_access_responder: two builds (WAIT_STATES 2 and 0) share
// stimulus and are compared every cycle against a transaction-offset model, plus literal checks.
module tb_storage_access_responder;

    localparam int DW  = 32;
    localparam int IW  = 32;
    localparam int MAW = 13;
    localparam int SAW = 15;

    localparam longint START = longint'(1) << MAW;
    localparam longint LAST  = START + (longint'(1) << SAW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic request = 1'b0;
    logic write_enable = 1'b0;
    logic [IW-1:0] address = '0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] st_read_data = '0;

    logic busy_2, done_2, error_2, swe_2, sre_2;
    logic [DW-1:0] rd_2, swd_2;
    logic [SAW-1:0] sa_2;
    logic busy_0, done_0, error_0, swe_0, sre_0;
    logic [DW-1:0] rd_0, swd_0;
    logic [SAW-1:0] sa_0;

    storage_access_responder #(
        .DATA_WIDTH(DW), .INPUT_WIDTH(IW), .MEMORY_ADDRESS_WIDTH(MAW),
        .STORAGE_ADDRESS_WIDTH(SAW), .WAIT_STATES(2)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .write_enable(write_enable),
        .address(address), .write_data(write_data), .busy(busy_2), .done(done_2),
        .error(error_2), .read_data(rd_2), .st_address(sa_2), .st_write_data(swd_2),
        .st_write_enable(swe_2), .st_read_enable(sre_2), .st_read_data(st_read_data)
    );

    storage_access_responder #(
        .DATA_WIDTH(DW), .INPUT_WIDTH(IW), .MEMORY_ADDRESS_WIDTH(MAW),
        .STORAGE_ADDRESS_WIDTH(SAW), .WAIT_STATES(0)
    ) dut_ws0 (
        .clock(clock), .reset(reset), .request(request), .write_enable(write_enable),
        .address(address), .write_data(write_data), .busy(busy_0), .done(done_0),
        .error(error_0), .read_data(rd_0), .st_address(sa_0), .st_write_data(swd_0),
        .st_write_enable(swe_0), .st_read_enable(sre_0), .st_read_data(st_read_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_log2[$];
    int done_log0[$];

    // Model: a transaction is described by its cycle offset d (1 = first cycle after the accept edge).
    typedef struct {
        bit          active;
        int          d;
        bit          w;
        bit          inr;
        logic [SAW-1:0] sa;
        logic [DW-1:0]  wd;
        bit          wd_known;
        logic [DW-1:0]  rd;
    } model_t;

    model_t m[2];
    int ws[2] = '{2, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit addr_in_range(input logic [IW-1:0] a);
        return longint'(a) >= START && longint'(a) <= LAST;
    endfunction

    function automatic int txn_len(input int i);
        return m[i].inr ? ws[i] + 2 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].active   = 1'b0;
            m[i].d        = 0;
            m[i].w        = 1'b0;
            m[i].inr      = 1'b0;
            m[i].sa       = '0;
            m[i].wd       = '0;
            m[i].wd_known = 1'b1;
            m[i].rd       = '0;
        end
    endtask

    task automatic model_advance(input int i);
        if (m[i].active) begin
            if (m[i].d == txn_len(i)) begin
                m[i].active = 1'b0;
            end else begin
                if (!m[i].w && m[i].inr && m[i].d == ws[i] + 1)
                    m[i].rd = st_read_data;
                if (!m[i].w && !m[i].inr)
                    m[i].rd = '0;
                m[i].d++;
            end
        end else if (request) begin
            m[i].active = 1'b1;
            m[i].d      = 1;
            m[i].w      = write_enable;
            m[i].inr    = addr_in_range(address);
            if (m[i].inr) begin
                m[i].sa       = SAW'((longint'(address) - START) & ((longint'(1) << SAW) - 1));
                m[i].wd       = write_data;
                m[i].wd_known = 1'b1;
            end else begin
                m[i].wd_known = 1'b0;
            end
        end
    endtask

    task automatic compare(input int i, input logic b, input logic dn, input logic er,
                           input logic [DW-1:0] rdv, input logic [SAW-1:0] sa,
                           input logic [DW-1:0] swd, input logic swe, input logic sre);
        bit in_access;
        string tag;
        tag = $sformatf("[ws=%0d]", ws[i]);
        in_access = m[i].active && m[i].inr && m[i].d <= ws[i] + 1;
        check({"busy", tag}, 64'(b), 64'(m[i].active));
        check({"done", tag}, 64'(dn), 64'(m[i].active && m[i].d == txn_len(i)));
        check({"error", tag}, 64'(er), 64'(m[i].active && m[i].d == txn_len(i) && !m[i].inr));
        check({"read_data", tag}, 64'(rdv), 64'(m[i].rd));
        check({"st_address", tag}, 64'(sa), 64'(m[i].sa));
        check({"st_read_enable", tag}, 64'(sre), 64'(in_access && !m[i].w));
        check({"st_write_enable", tag}, 64'(swe), 64'(in_access && m[i].w && m[i].d == 1));
        if (in_access || (!m[i].active && m[i].wd_known && m[i].d == 0))
            check({"st_write_data", tag}, 64'(swd), 64'(m[i].wd));
    endtask

    always @(negedge clock) begin
        cyc++;
        if (reset)
            model_reset();
        compare(0, busy_2, done_2, error_2, rd_2, sa_2, swd_2, swe_2, sre_2);
        compare(1, busy_0, done_0, error_0, rd_0, sa_0, swd_0, swe_0, sre_0);
        if (done_2) done_log2.push_back(cyc);
        if (done_0) done_log0.push_back(cyc);
        if (!reset) begin
            model_advance(0);
            model_advance(1);
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Presents a request for one edge; returns #1 into the first cycle after the accept edge.
    task automatic access_start(input logic we, input logic [IW-1:0] a, input logic [DW-1:0] wd);
        request      = 1'b1;
        write_enable = we;
        address      = a;
        write_data   = wd;
        cycle();
        request = 1'b0;
    endtask

    int n_before;
    logic [IW-1:0] ra;

    initial begin
        repeat (2) cycle();
        reset = 1'b0;
        repeat (2) cycle();

        check("reset_busy", 64'(busy_2), 64'(0));
        check("reset_read_data", 64'(rd_2), 64'(0));

        // Read at 0x2005.
        st_read_data = 32'hDEADBEEF;
        access_start(1'b0, 32'h0000_2005, 32'h0);
        check("rd_k1_st_address", 64'(sa_2), 64'h5);
        check("rd_k1_st_read_enable", 64'(sre_2), 64'(1));
        check("rd_k1_busy", 64'(busy_2), 64'(1));
        check("ws0_k1_st_read_enable", 64'(sre_0), 64'(1));
        cycle();
        check("ws0_k2_done", 64'(done_0), 64'(1));
        check("ws0_k2_read_data", 64'(rd_0), 64'hDEADBEEF);
        check("rd_k2_st_read_enable", 64'(sre_2), 64'(1));
        cycle();
        check("rd_k3_st_read_enable", 64'(sre_2), 64'(1));
        check("rd_k3_done", 64'(done_2), 64'(0));
        cycle();
        check("rd_k4_done", 64'(done_2), 64'(1));
        check("rd_k4_error", 64'(error_2), 64'(0));
        check("rd_k4_read_data", 64'(rd_2), 64'hDEADBEEF);
        check("rd_k4_st_read_enable", 64'(sre_2), 64'(0));
        cycle();
        check("rd_k5_busy", 64'(busy_2), 64'(0));
        check("rd_k5_read_data_held", 64'(rd_2), 64'hDEADBEEF);

        // Write to the top of the window.
        st_read_data = 32'h5555_5555;
        access_start(1'b1, 32'h0000_3FFF, 32'h1234_5678);
        check("wr_k1_st_address", 64'(sa_2), 64'h1FFF);
        check("wr_k1_st_write_enable", 64'(swe_2), 64'(1));
        check("wr_k1_st_write_data", 64'(swd_2), 64'h1234_5678);
        cycle();
        check("wr_k2_st_write_enable", 64'(swe_2), 64'(0));
        repeat (2) cycle();
        check("wr_k4_done", 64'(done_2), 64'(1));
        check("wr_k4_read_data_unchanged", 64'(rd_2), 64'hDEADBEEF);
        repeat (2) cycle();

        // One below the window: read fault.
        access_start(1'b0, 32'h0000_1FFF, 32'h0);
        check("flo_k1_strobes", 64'({swe_2, sre_2}), 64'(0));
        check("flo_k1_done", 64'(done_2), 64'(0));
        cycle();
        check("flo_k2_done", 64'(done_2), 64'(1));
        check("flo_k2_error", 64'(error_2), 64'(1));
        check("flo_k2_read_data", 64'(rd_2), 64'(0));
        repeat (2) cycle();

        // One above the window: write fault.
        access_start(1'b1, 32'h0000_A000, 32'hFFFF_FFFF);
        check("fhi_k1_strobes", 64'({swe_2, sre_2}), 64'(0));
        cycle();
        check("fhi_k2_error", 64'(error_2), 64'(1));
        repeat (2) cycle();

        access_start(1'b0, 32'h0000_2000, 32'h0);
        check("lo_edge_st_address", 64'(sa_2), 64'h0);
        repeat (5) cycle();
        access_start(1'b0, 32'h0000_9FFF, 32'h0);
        check("hi_edge_st_address", 64'(sa_2), 64'h7FFF);
        repeat (5) cycle();

        // Request held high through two accesses.
        n_before     = done_log2.size();
        request      = 1'b1;
        write_enable = 1'b0;
        address      = 32'h0000_2040;
        repeat (6) cycle();
        request = 1'b0;
        repeat (6) cycle();
        check("held_done_count", 64'(done_log2.size() - n_before), 64'(2));
        if (done_log2.size() - n_before == 2)
            check("held_done_spacing", 64'(done_log2[n_before+1] - done_log2[n_before]), 64'(5));

        // Asynchronous reset in the middle of an access.
        st_read_data = 32'hCAFE_F00D;
        access_start(1'b0, 32'h0000_2300, 32'h0);
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'({busy_2, busy_0}), 64'(0));
        check("arst_strobes", 64'({sre_2, swe_2}), 64'(0));
        check("arst_st_address", 64'(sa_2), 64'(0));
        check("arst_read_data", 64'(rd_2), 64'(0));
        check("arst_done_error", 64'({done_2, error_2}), 64'(0));
        n_before = done_log2.size();
        repeat (2) cycle();
        reset = 1'b0;
        repeat (5) cycle();
        check("arst_no_done", 64'(done_log2.size()), 64'(n_before));
        st_read_data = 32'h0BAD_CAFE;
        access_start(1'b0, 32'h0000_2ABC, 32'h0);
        check("post_rst_st_address", 64'(sa_2), 64'h0ABC);
        repeat (3) cycle();
        check("post_rst_done", 64'(done_2), 64'(1));
        check("post_rst_read_data", 64'(rd_2), 64'h0BAD_CAFE);
        repeat (2) cycle();

        // Randomised traffic, checked every cycle by the model.
        repeat (600) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h0000_2000;
                1: ra = 32'h0000_9FFF;
                2: ra = 32'h0000_1FFF;
                3: ra = 32'h0000_A000;
                4, 5: ra = 32'h0000_2000 + $urandom_range(0, 32'h7FFF);
                6: ra = $urandom_range(0, 32'h1FFF);
                default: ra = $urandom;
            endcase
            request      = ($urandom_range(0, 2) != 0);
            write_enable = $urandom_range(0, 1) == 1;
            address      = ra;
            write_data   = $urandom;
            st_read_data = $urandom;
            cycle();
        end
        request = 1'b0;
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/storage_access_responder.md
Name: storage_access_responder

Overview:
- Storage-side responder for the split memory map. The address decoder flags CPU accesses above the memory region as storage accesses; this block serves those accesses.
- Accepts one storage request at a time and checks its address range.
- Translates the address into the storage-local space and drives a slow storage port with a configurable number of wait states.
- Returns read data with a one-cycle completion pulse and a busy/stall indication to the CPU.

Parameters:
DATA_WIDTH, 32, width of read/write data
INPUT_WIDTH, 32, width of CPU-side address
MEMORY_ADDRESS_WIDTH, 13, memory region size is 2**MEMORY_ADDRESS_WIDTH words; storage starts at STORAGE_START = 2**MEMORY_ADDRESS_WIDTH
STORAGE_ADDRESS_WIDTH, 15, storage-local address width; storage spans STORAGE_START .. STORAGE_START + 2**STORAGE_ADDRESS_WIDTH - 1
WAIT_STATES, 2, extra cycles the storage port needs per access (0 legal)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
request  input  1  CPU storage request, sampled only in IDLE
write_enable  input  1  1 = write, 0 = read; sampled with request
address  input  INPUT_WIDTH  CPU (global) address
write_data  input  DATA_WIDTH  data for writes
busy  output  1  high while a request is in progress (stall CPU)
done  output  1  one-cycle pulse at completion
error  output  1  valid with done; address outside the storage range
read_data  output  DATA_WIDTH  read result; held until next accepted read
st_address  output  STORAGE_ADDRESS_WIDTH  storage-local address
st_write_data  output  DATA_WIDTH  data to storage
st_write_enable  output  1  storage write strobe
st_read_enable  output  1  storage read enable
st_read_data  input  DATA_WIDTH  data from storage

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-access):
  - state = IDLE.
  - busy, done, error, st_write_enable, st_read_enable = 0.
  - read_data, st_address, st_write_data = 0.
  - Wait counter = 0.
  - Any in-flight access is abandoned; done is not pulsed.
- FSM states: IDLE, ACCESS, FAULT, DONE. busy = (state != IDLE).
- IDLE:
  - On request=1 at a clock edge, register write_enable, write_data and the address.
  - In range (STORAGE_START <= address <= STORAGE_START + 2**STORAGE_ADDRESS_WIDTH - 1):
    - st_address = address - STORAGE_START, truncated to STORAGE_ADDRESS_WIDTH.
    - Counter = WAIT_STATES.
    - Go to ACCESS.
  - Out of range: go to FAULT.
  - request=0: stay in IDLE.
- ACCESS:
  - Lasts WAIT_STATES+1 cycles.
  - st_address and st_write_data are held stable.
  - Read: st_read_enable = 1 for every ACCESS cycle.
  - Write: st_write_enable = 1 in the first ACCESS cycle only, then 0.
  - Counter decrements each cycle. At the edge ending the cycle where counter == 0:
    - Read: capture st_read_data into read_data.
    - Go to DONE.
- FAULT:
  - Lasts one cycle; no storage strobe is asserted.
  - Go to DONE with error latched to 1.
  - read_data is set to 0 if the faulting request was a read.
- DONE:
  - Lasts one cycle, with done = 1 and error valid.
  - Then go to IDLE; done and error return to 0.
- Latency from the accept edge to the done cycle:
  - In range: WAIT_STATES + 2 cycles (4 at default).
  - Fault: 2 cycles.
- Requests and handshake:
  - request is ignored in ACCESS, FAULT and DONE. The CPU holds request while busy; a request still high after DONE is accepted on the first IDLE edge, i.e. a new access.
  - There is no back-to-back acceptance in the DONE cycle; minimum spacing between accepts is WAIT_STATES + 3 cycles.
- Boundaries:
  - address == STORAGE_START maps to st_address 0.
  - address == STORAGE_START + 2**STORAGE_ADDRESS_WIDTH - 1 maps to the all-ones st_address.
  - One below or one above this range: fault.
- Writes never modify read_data.

Test Plan:
- Read at defaults, address = 0x2005, st_read_data = 0xDEADBEEF:
  - Accept edge k; st_address = 0x0005; st_read_enable high for cycles k+1..k+3.
  - done = 1, error = 0 at k+4; read_data = 0xDEADBEEF and held afterwards; busy high k+1..k+4.
- Write to address 0x3FFF, write_data = 0x12345678:
  - st_address = 0x1FFF; st_write_enable high exactly one cycle (k+1) with st_write_data = 0x12345678.
  - done at k+4; read_data unchanged.
- Range edges:
  - Address 0x1FFF gives a fault: no strobes, done + error = 1 at k+2.
  - Address 0xA000 gives a fault.
  - Address 0x2000 gives st_address 0.
  - Address 0x9FFF gives st_address 0x7FFF.
- request held high continuously through two accesses:
  - Second access accepted on the edge after the DONE cycle.
  - Exactly two done pulses, spaced 5 cycles apart.
- reset asserted asynchronously mid-ACCESS (between edges):
  - All outputs go to 0 immediately; no done pulse.
  - After deassertion, a new request completes normally.
- WAIT_STATES = 0 build, read:
  - ACCESS lasts 1 cycle; done at k+2; data captured correctly.
